// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard over the open-drain ps2_clk/ps2_data pair.
// The top level ties each line to 1'bz whenever its output enable is low.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // The cycle counts are worked out for a 100 MHz clock; anything slower than 1 MHz is unsupported.
  if (CLK_FREQ_HZ < 1_000_000) begin : g_clk_freq_too_low
    $error("ps2_host_tx: CLK_FREQ_HZ too low");
  end

  localparam int CNT_W = 21;
  localparam int FW    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_AT     = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [FW-1:0]    FILTER_LAST  = FW'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, INHIBIT, SEND, ACK} state_t;

  state_t           state;
  logic [1:0]       raw;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       filt;
  logic [FW-1:0]    fcnt [2];
  logic             clk_filt_d;
  logic             clk_fall;
  logic [7:0]       data_q;
  logic             par_q;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] cnt;
  logic             ack_bit;

  // Index 0 is the clock line, index 1 the data line.
  assign raw      = {ps2_data_in, ps2_clk_in};
  assign clk_fall = clk_filt_d & ~filt[0];

  // Synchronise both lines, then only accept a new level after FILTER_CYCLES matching samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      clk_filt_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync_a     <= raw;
      sync_b     <= sync_a;
      clk_filt_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILTER_LAST) begin
          filt[i] <= sync_b[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Transfer sequencer: inhibit, start bit, clock out data/parity/stop on device edges, check the ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'b00;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      data_q      <= 8'h00;
      par_q       <= 1'b0;
      bitcnt      <= 4'd0;
      cnt         <= '0;
      ack_bit     <= 1'b1;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            data_q     <= tx_data;
            par_q      <= ~^tx_data;
            bitcnt     <= 4'd0;
            cnt        <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= SEND;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == START_AT) ps2_data_oe <= 1'b1;
          end
        end
        SEND: begin
          if (clk_fall) begin
            cnt    <= '0;
            bitcnt <= bitcnt + 4'd1;
            case (bitcnt)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: ps2_data_oe <= ~data_q[bitcnt[2:0]];
              4'd8:  ps2_data_oe <= ~par_q;
              4'd9:  ps2_data_oe <= 1'b0;
              4'd10: begin
                ps2_data_oe <= 1'b0;
                ack_bit     <= filt[1];
                state       <= ACK;
              end
              default: ps2_data_oe <= 1'b0;
            endcase
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            err_code    <= 2'b01;
            state       <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          if (ack_bit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            err_code    <= 2'b10;
            state       <= IDLE;
          end else if (filt == 2'b11) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (clk_fall) begin
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            err_code    <= 2'b01;
            state       <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks the host and checks each bit against a scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT = 200;
  localparam int TIMEOUT = 3000;
  localparam int FILTER  = 8;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       glitch_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] err_code_seen = 2'b00;
  logic [1:0] err_oe = 2'b00;
  logic       ready_at_exit = 1'b1;
  logic       ready_after_exit = 1'b0;
  bit         chk_ready_next = 1'b0;

  // Wired-AND bus: host, device and glitch injector can each pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ   (100_000_000),
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_CYCLES (FILTER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Records done/error pulses and what the outputs looked like around them.
  always @(negedge clk) begin
    if (chk_ready_next) begin
      ready_after_exit = tx_ready;
      chk_ready_next   = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      ready_at_exit  = tx_ready;
      chk_ready_next = 1'b1;
    end
    if (error === 1'b1) begin
      err_cnt++;
      err_code_seen  = err_code;
      err_oe         = {ps2_clk_oe, ps2_data_oe};
      ready_at_exit  = tx_ready;
      chk_ready_next = 1'b1;
    end
  end

  // Hard stop if the run ever wedges.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_request(input logic [7:0] data);
    int t;
    for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
    exp_q.push_back(~^data);
    exp_q.push_back(1'b1);
    tx_data  = data;
    tx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy !== 1'b1 && t < 100);
    tx_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL accept 0x%h: busy=%b tx_ready=%b clk_oe=%b, required 1 0 1",
               data, busy, tx_ready, ps2_clk_oe);
    end
  endtask

  task automatic check_inhibit();
    int   n;
    logic first_data_oe;
    n = 0;
    first_data_oe = ps2_data_oe;
    while (ps2_clk_oe === 1'b1 && n < INHIBIT + 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != INHIBIT) begin
      miscompares++;
      $display("[TB] FAIL inhibit_len: clk_oe high %0d cycles, required %0d", n, INHIBIT);
    end
    vectors++;
    if (first_data_oe !== 1'b0 || ps2_data_oe !== 1'b1 || ps2_data_in !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_bit: data_oe first=%b at_release=%b data_in=%b, required 0 1 0",
               first_data_oe, ps2_data_oe, ps2_data_in);
    end
  endtask

  task automatic device_run(input bit ack, input bit glitch, input int edges);
    bit b;
    bit e_bit;
    wait_cycles(20);
    for (int e = 1; e <= edges; e++) begin
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      dev_clk_low = 1'b0;
      if (e <= 10) begin
        b = ps2_data_in;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bit%0d: got %b, required nothing queued", e, b);
        end else begin
          e_bit = exp_q.pop_front();
          if (b !== e_bit) begin
            miscompares++;
            $display("[TB] FAIL bit%0d: got %b, required %b", e, b, e_bit);
          end
        end
        if (e == 10 && ack) dev_data_low = 1'b1;
      end
      if (glitch && e == 4) begin
        wait_cycles(10);
        glitch_low = 1'b1;
        wait_cycles(3);
        glitch_low = 1'b0;
        wait_cycles(HALF - 13);
      end else begin
        wait_cycles(HALF);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_byte(input logic [7:0] data, input bit ack, input bit glitch);
    int t, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_request(data);
    check_inhibit();
    device_run(ack, glitch, 11);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 2000) begin
      miscompares++;
      $display("[TB] FAIL result_wait 0x%h: no done/error after %0d cycles, required one", data, t);
    end
    wait_cycles(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    vectors++;
    if ({busy, done, error, err_code, ps2_clk_oe, ps2_data_oe} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: busy/done/error/code/oe=%b, required 0000000",
               {busy, done, error, err_code, ps2_clk_oe, ps2_data_oe});
    end
    reset = 1'b0;
    wait_cycles(2);
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: tx_ready=%b, required 1", tx_ready);
    end
  endtask

  task automatic test_send_ed();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_byte(8'hED, 1'b1, 1'b0);
    vectors++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      miscompares++;
      $display("[TB] FAIL send_ed: done=%0d error=%0d pulses, required 1 0", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (ready_at_exit !== 1'b0 || ready_after_exit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL exit_ready: tx_ready at done=%b next=%b, required 0 1", ready_at_exit, ready_after_exit);
    end
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h01};
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) run_byte(bytes[i], 1'b1, 1'b0);
    vectors++;
    if (done_cnt != d0 + 3 || err_cnt != e0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: done=%0d error=%0d leftover=%0d, required 3 0 0",
               done_cnt - d0, err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_nack();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_byte(8'h5A, 1'b0, 1'b0);
    vectors++;
    if (err_cnt != e0 + 1 || done_cnt != d0 || err_code_seen !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL nack: error=%0d done=%0d code=%b, required 1 0 10",
               err_cnt - e0, done_cnt - d0, err_code_seen);
    end
    vectors++;
    if (err_oe !== 2'b00 || ready_after_exit !== 1'b1 || err_code !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL nack_exit: oe=%b ready_next=%b held_code=%b, required 00 1 10",
               err_oe, ready_after_exit, err_code);
    end
  endtask

  task automatic test_timeout();
    int n;
    send_request(8'h3C);
    check_inhibit();
    n = 0;
    while (error !== 1'b1 && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != TIMEOUT) begin
      miscompares++;
      $display("[TB] FAIL timeout_len: error %0d cycles after release, required %0d", n, TIMEOUT);
    end
    vectors++;
    if (err_code !== 2'b01 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_exit: code=%b clk_oe=%b data_oe=%b, required 01 0 0",
               err_code, ps2_clk_oe, ps2_data_oe);
    end
    exp_q.delete();
    wait_cycles(3);
  endtask

  task automatic test_glitch();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_byte(8'hC3, 1'b1, 1'b1);
    vectors++;
    if (done_cnt != d0 + 1 || err_cnt != e0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch: done=%0d error=%0d leftover=%0d, required 1 0 0",
               done_cnt - d0, err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send_request(8'hA5);
    check_inhibit();
    device_run(1'b1, 1'b0, 5);
    exp_q.delete();
    vectors++;
    if (ps2_data_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_data_oe: data_oe=%b after edge 5, required 1", ps2_data_oe);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_release: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    vectors++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: tx_ready=%b busy=%b done=%0d error=%0d, required 1 0 0 0",
               tx_ready, busy, done_cnt - d0, err_cnt - e0);
    end
    d0 = done_cnt;
    run_byte(8'hF4, 1'b1, 1'b0);
    vectors++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL after_reset_send: done=%0d leftover=%0d, required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    $display("[TB] ps2_host_tx bench starting");
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
